// File: rtl/param_sync_fifo_pkg.sv
// rtl/param_sync_fifo_pkg.sv - shared defaults and mode enum for param_sync_fifo
package param_sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/param_sync_fifo_ptr.sv
// rtl/param_sync_fifo_ptr.sv - modulo-DEPTH pointer, wraps DEPTH-1 -> 0
module fifo_ptr #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       adv,
    output logic [$clog2(DEPTH)-1:0]   ptr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - synchronous FIFO, any depth, registered-read or FWFT output
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                rd_en,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic                                full,
    output logic                                empty,
    output logic                                almost_full,
    output logic                                almost_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
    output logic                                wr_ack,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = count_width(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam fifo_mode_e    MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // A read frees a slot in the same cycle, so a full FIFO can still take a write.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .adv (wr_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .adv (rd_acc),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_acc && !rd_acc) begin
            count <= count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && empty;
        end
    end

    // Storage is deliberately not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            assign data_out = mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (rd_acc) begin
                    data_reg <= mem[rd_ptr];
                end
            end

            assign data_out = data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - self-checking bench: depth-8 registered-read and depth-5 FWFT instances
module tb_param_sync_fifo;
    import param_sync_fifo_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int AD = DEF_FIFO_DEPTH;
    localparam int BD = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          a_rst = 1'b1, a_wr = 1'b0, a_rd = 1'b0;
    logic [DW-1:0] a_din = '0, a_dout;
    logic          a_full, a_empty, a_af, a_ae, a_ack, a_ovf, a_udf;
    logic [3:0]    a_count;

    logic          b_rst = 1'b1, b_wr = 1'b0, b_rd = 1'b0;
    logic [DW-1:0] b_din = '0, b_dout;
    logic          b_full, b_empty, b_af, b_ae, b_ack, b_ovf, b_udf;
    logic [2:0]    b_count;

    param_sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(AD), .FWFT(0)) dut_a (
        .clk(clk), .rst(a_rst), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
        .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_count), .wr_ack(a_ack), .overflow(a_ovf),
        .underflow(a_udf)
    );

    param_sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(BD), .FWFT(1)) dut_b (
        .clk(clk), .rst(b_rst), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
        .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_count), .wr_ack(b_ack), .overflow(b_ovf),
        .underflow(b_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue per FIFO plus the expected pulse outputs.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic          ma_ack = 0, ma_ovf = 0, ma_udf = 0, mb_ack = 0, mb_ovf = 0, mb_udf = 0;
    logic [DW-1:0] ma_dout = '0;
    bit            ma_live = 0, mb_live = 0;

    always @(posedge clk) begin : model_a
        bit rok, wok;
        if (a_rst) begin
            qa.delete();
            ma_ack = 0; ma_ovf = 0; ma_udf = 0; ma_dout = '0; ma_live = 1;
        end else begin
            rok = a_rd && (qa.size() > 0);
            wok = a_wr && ((qa.size() < AD) || rok);
            ma_udf = a_rd && (qa.size() == 0);
            ma_ovf = a_wr && !wok;
            ma_ack = wok;
            if (rok) ma_dout = qa.pop_front();
            if (wok) qa.push_back(a_din);
        end
    end

    always @(posedge clk) begin : model_b
        bit rok, wok;
        if (b_rst) begin
            qb.delete();
            mb_ack = 0; mb_ovf = 0; mb_udf = 0; mb_live = 1;
        end else begin
            rok = b_rd && (qb.size() > 0);
            wok = b_wr && ((qb.size() < BD) || rok);
            mb_udf = b_rd && (qb.size() == 0);
            mb_ovf = b_wr && !wok;
            mb_ack = wok;
            if (rok) void'(qb.pop_front());
            if (wok) qb.push_back(b_din);
        end
    end

    always @(negedge clk) begin
        if (ma_live) begin
            chk("a_count", 32'(a_count), qa.size());
            chk("a_full", 32'(a_full), 32'(qa.size() == AD));
            chk("a_empty", 32'(a_empty), 32'(qa.size() == 0));
            chk("a_almost_full", 32'(a_af), 32'(qa.size() >= AD - 1));
            chk("a_almost_empty", 32'(a_ae), 32'(qa.size() <= 1));
            chk("a_wr_ack", 32'(a_ack), 32'(ma_ack));
            chk("a_overflow", 32'(a_ovf), 32'(ma_ovf));
            chk("a_underflow", 32'(a_udf), 32'(ma_udf));
            chk("a_data_out", 32'(a_dout), 32'(ma_dout));
        end
        if (mb_live) begin
            chk("b_count", 32'(b_count), qb.size());
            chk("b_full", 32'(b_full), 32'(qb.size() == BD));
            chk("b_empty", 32'(b_empty), 32'(qb.size() == 0));
            chk("b_almost_full", 32'(b_af), 32'(qb.size() >= BD - 1));
            chk("b_almost_empty", 32'(b_ae), 32'(qb.size() <= 1));
            chk("b_wr_ack", 32'(b_ack), 32'(mb_ack));
            chk("b_overflow", 32'(b_ovf), 32'(mb_ovf));
            chk("b_underflow", 32'(b_udf), 32'(mb_udf));
            if (qb.size() > 0) chk("b_head", 32'(b_dout), 32'(qb[0]));
        end
    end

    task automatic a_op(input logic w, input logic [DW-1:0] d, input logic r);
        a_wr = w; a_din = d; a_rd = r;
        @(posedge clk); #1;
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic b_op(input logic w, input logic [DW-1:0] d, input logic r);
        b_wr = w; b_din = d; b_rd = r;
        @(posedge clk); #1;
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 a_rst = 1'b0;
        chk("a_rst_count", 32'(a_count), 32'd0);
        chk("a_rst_empty", 32'(a_empty), 32'd1);
        chk("a_rst_full", 32'(a_full), 32'd0);
        chk("a_rst_ae", 32'(a_ae), 32'd1);
        chk("a_rst_af", 32'(a_af), 32'd0);
        chk("a_rst_dout", 32'(a_dout), 32'd0);

        for (int i = 1; i <= 8; i++) begin
            a_op(1'b1, DW'(i), 1'b0);
            chk("a_fill_ack", 32'(a_ack), 32'd1);
            chk("a_fill_af", 32'(a_af), (i >= 7) ? 32'd1 : 32'd0);
        end
        chk("a_full_count", 32'(a_count), 32'd8);
        chk("a_full_flag", 32'(a_full), 32'd1);

        a_op(1'b1, 16'h0009, 1'b0);
        chk("a_ovf_pulse", 32'(a_ovf), 32'd1);
        chk("a_ovf_count", 32'(a_count), 32'd8);
        chk("a_ovf_noack", 32'(a_ack), 32'd0);

        for (int i = 1; i <= 8; i++) begin
            a_op(1'b0, '0, 1'b1);
            chk("a_drain_data", 32'(a_dout), 32'(i));
        end
        chk("a_drain_empty", 32'(a_empty), 32'd1);
        a_op(1'b0, '0, 1'b1);
        chk("a_udf_pulse", 32'(a_udf), 32'd1);
        chk("a_udf_hold", 32'(a_dout), 32'h0008);

        for (int i = 1; i <= 8; i++) a_op(1'b1, DW'(i), 1'b0);
        a_op(1'b1, 16'hAAAA, 1'b1);
        chk("a_both_full_data", 32'(a_dout), 32'h0001);
        chk("a_both_full_count", 32'(a_count), 32'd8);
        chk("a_both_full_noovf", 32'(a_ovf), 32'd0);
        for (int i = 2; i <= 8; i++) begin
            a_op(1'b0, '0, 1'b1);
            chk("a_both_full_order", 32'(a_dout), 32'(i));
        end
        a_op(1'b0, '0, 1'b1);
        chk("a_aaaa_last", 32'(a_dout), 32'hAAAA);
        chk("a_aaaa_empty", 32'(a_empty), 32'd1);

        a_op(1'b1, 16'h1234, 1'b1);
        chk("a_both_empty_udf", 32'(a_udf), 32'd1);
        chk("a_both_empty_ack", 32'(a_ack), 32'd1);
        chk("a_both_empty_count", 32'(a_count), 32'd1);

        for (int i = 0; i < 4; i++) a_op(1'b1, DW'(16'h2000 + i), 1'b0);
        chk("a_pre_rst_count", 32'(a_count), 32'd5);
        a_rst = 1'b1; a_wr = 1'b1; a_din = 16'hDEAD;
        @(posedge clk); #1;
        a_rst = 1'b0; a_wr = 1'b0;
        chk("a_mid_rst_count", 32'(a_count), 32'd0);
        chk("a_mid_rst_empty", 32'(a_empty), 32'd1);
        chk("a_mid_rst_ack", 32'(a_ack), 32'd0);
        chk("a_mid_rst_dout", 32'(a_dout), 32'd0);

        // Mixed traffic: fill past full with some reads, then drain past empty.
        for (int i = 0; i < 48; i++) begin
            if (i < 24) a_op(1'b1, DW'(16'h5000 + i), (i % 3) == 0);
            else        a_op((i % 3) == 0, DW'(16'h5000 + i), 1'b1);
        end

        b_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b_op(1'b1, DW'(16'h0100 + i), i >= 2);
            chk("b_head_lit", 32'(b_dout), (i < 2) ? 32'h0100 : 32'(16'h0100 + i - 1));
        end
        chk("b_loop_count", 32'(b_count), 32'd2);
        b_op(1'b0, '0, 1'b1);
        chk("b_tail_head", 32'(b_dout), 32'h0113);
        b_op(1'b0, '0, 1'b1);
        chk("b_drained_empty", 32'(b_empty), 32'd1);
        b_op(1'b0, '0, 1'b1);
        chk("b_udf_pulse", 32'(b_udf), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 16, data bus width in bits (>=1).
REQ-002 Parameter FIFO_DEPTH, default 8, capacity in words (>=2; any value, not only powers of two).
REQ-003 Parameter AF_LEVEL, default FIFO_DEPTH-1, occupancy at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 1, occupancy at or below which almost_empty asserts.
REQ-005 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset; one clock, synchronous, active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 rd_en  input  1  read request (pop).
REQ-011 data_out  output  DATA_WIDTH  read data.
REQ-012 full, empty, almost_full, almost_empty  output  1 each  occupancy status.
REQ-013 count  output  $clog2(FIFO_DEPTH+1)  current occupancy.
REQ-014 wr_ack, overflow, underflow  output  1 each  registered per-request status pulses.

Function
REQ-015 Write accepted when wr_en && (!full || rd_accepted); word stored at wr_ptr, wr_ptr advances.
REQ-016 Read accepted when rd_en && !empty; rd_ptr advances.
REQ-017 Pointers wrap from FIFO_DEPTH-1 to 0; no power-of-two assumption.
REQ-018 count: +1 on write-only, -1 on read-only, unchanged on both or neither; never exceeds FIFO_DEPTH, never below 0.
REQ-019 Full and both requested: read and write both accepted, count stays FIFO_DEPTH, no overflow.
REQ-020 Empty and both requested: only write accepted, count becomes 1, underflow pulses.
REQ-021 full = (count==FIFO_DEPTH); empty = (count==0); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); all combinational from registered count.
REQ-022 wr_ack high for one cycle following each accepted write; low otherwise.
REQ-023 overflow high for one cycle following a rejected write (wr_en while full without accepted read).
REQ-024 underflow high for one cycle following rd_en while empty.
REQ-025 FWFT=0: data_out registered, updated the cycle after an accepted read with the popped word; holds its value otherwise.
REQ-026 FWFT=1: data_out = mem[rd_ptr] combinationally; valid whenever !empty; first written word visible the cycle after write; don't-care when empty.
REQ-027 Data order strictly first-in first-out across any number of wraps.

Reset
REQ-028 rst high at a clock edge: wr_ptr, rd_ptr, count = 0; wr_ack, overflow, underflow = 0; registered data_out = 0.
REQ-029 After reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
REQ-030 Reset dominates wr_en/rd_en in the same cycle; mid-operation reset discards all stored words; memory contents not cleared.

Structure
REQ-031 Shared package holds default DATA_WIDTH/FIFO_DEPTH constants and a mode enum (FIFO_STD, FIFO_FWFT) used by RTL and bench.
REQ-032 One sub-module fifo_ptr (parameter DEPTH; inputs clk, rst, adv; output ptr) wrapping at DEPTH-1, instantiated for write and read pointers.
REQ-033 Storage is a flat register array of FIFO_DEPTH x DATA_WIDTH; no vendor primitives.

Verification (DATA_WIDTH=16, FIFO_DEPTH=8 unless noted)
REQ-034 Reset, then 8 writes 0x0001..0x0008 -> wr_ack each following cycle, count=8, full=1, almost_full=1 from count 7; 9th write -> overflow pulse, count stays 8.
REQ-035 From full, 8 reads (FWFT=0) -> data_out 0x0001..0x0008 one cycle after each read, empty=1 at end; extra read -> underflow pulse, data_out holds 0x0008.
REQ-036 Full plus simultaneous wr_en/rd_en with data_in=0xAAAA -> read 0x0001, count stays 8, no overflow; 0xAAAA emerges last after 7 further reads.
REQ-037 Empty plus simultaneous wr_en/rd_en, data_in=0x1234 -> underflow pulse, wr_ack pulse, count=1.
REQ-038 FIFO_DEPTH=5, FWFT=1: 20 interleaved writes/reads forcing 4 wraps -> data_out shows head word without read latency, order preserved.
REQ-039 Reset asserted with count=5 and wr_en=1 -> next cycle count=0, empty=1, wr_ack=0, data_out=0.
